// File: rtl/led_vu_pkg.sv
// ---------------------------------------------------------------------------
// led_vu_pkg
// Shared types and helpers for the LED bar-graph display blocks.
//   level_t       : 4-bit LED level, 0 (all off) .. NUM_LEDS (all on)
//   peak_state_t  : peak-dot ballistics states
//   therm2level() : thermometer code -> level (highest set bit + 1)
//   level2therm() : level -> thermometer code with bits [lvl-1:0] set
//   level2dot()   : level -> single lit LED at bit lvl-1 (0 gives no LED)
// ---------------------------------------------------------------------------
package led_vu_pkg;

   localparam int NUM_LEDS = 8;

   typedef logic [3:0] level_t;

   typedef enum logic [1:0] {
      TRACK,
      HOLD,
      FALL
   } peak_state_t;

   // Only the topmost set bit matters, so a code with holes collapses to
   // the level of its highest lit LED.
   function automatic level_t therm2level(input logic [NUM_LEDS-1:0] code);
      level_t lvl;
      lvl = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         if (code[i]) lvl = level_t'(i + 1);
      end
      return lvl;
   endfunction

   function automatic logic [NUM_LEDS-1:0] level2therm(input level_t lvl);
      logic [NUM_LEDS-1:0] code;
      code = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         if (i < int'(lvl)) code[i] = 1'b1;
      end
      return code;
   endfunction

   function automatic logic [NUM_LEDS-1:0] level2dot(input level_t lvl);
      logic [NUM_LEDS-1:0] code;
      code = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         if (int'(lvl) == i + 1) code[i] = 1'b1;
      end
      return code;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// ---------------------------------------------------------------------------
// led_tick_gen
// Free-running prescaler producing a one-clock tick every DIV clocks.
// Nothing but reset restarts it, so the tick phase is fixed from reset.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (counter returns to 0)
//   tick  : high for one clock while the count sits at DIV-1
// DIV must be at least 2.
// ---------------------------------------------------------------------------
module led_tick_gen #(
   parameter int DIV = 2_500_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   // The tick is decoded straight from the count so it lines up with the
   // cycle in which the counter is about to wrap back to zero.
   assign tick = (count == LAST);

   // Count 0..DIV-1 and wrap; the wrap happens on the same edge that
   // consumes the tick, giving exactly one tick per DIV clocks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/led_peak_hold.sv
// ---------------------------------------------------------------------------
// led_peak_hold
// VU-meter ballistics stage between the bar-graph driver and the LEDs:
// instant attack and rate-limited decay on the bar, plus a peak dot that
// holds at the recent maximum and then falls one LED per decay tick.
// Three register stages: level decode, bar/peak update, output drive.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   LED_in  : thermometer code from the bar-graph driver (bit0 = lowest)
//   peak_en : 1 overlays the peak dot on the bar, 0 shows the bar only
//   LED_out : registered LED drive
// HOLD_CYCLES and DECAY_CYCLES must both be at least 2.
// ---------------------------------------------------------------------------
module led_peak_hold
   import led_vu_pkg::*;
#(
   parameter int HOLD_CYCLES  = 25_000_000,
   parameter int DECAY_CYCLES = 2_500_000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_LEDS-1:0] LED_in,
   input  logic                peak_en,
   output logic [NUM_LEDS-1:0] LED_out
);

   localparam int HW = $clog2(HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

   level_t        in_lvl;
   level_t        bar_lvl;
   level_t        peak_lvl;
   logic [HW-1:0] hold_cnt;
   peak_state_t   state;

   level_t        barNext;
   level_t        peakNext;
   logic [HW-1:0] holdNext;
   peak_state_t   stateNext;
   logic          tick;
   logic          capture;
   logic [NUM_LEDS-1:0] dotMask;

   // One shared decay timebase drives both the bar and the falling peak,
   // so they step down on the same clocks.
   led_tick_gen #(
      .DIV (DECAY_CYCLES)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // Bar ballistics: any input at or above the bar snaps it up, and that
   // beats a coincident tick, so a steady input never lets the bar sag.
   // The attack branch also catches bar_lvl==0, so the decrement cannot
   // underflow.
   always_comb begin
      barNext = bar_lvl;
      if (in_lvl >= bar_lvl) begin
         barNext = in_lvl;
      end else if (tick) begin
         barNext = bar_lvl - 4'd1;
      end
   end

   // Peak-dot FSM. A capture (input at or above the held peak) restarts the
   // hold from any state, which is how an equal-level input keeps the dot
   // pinned. After the hold expires the dot falls on ticks until it is no
   // longer above the bar, then TRACK keeps it glued to the bar top.
   always_comb begin
      peakNext  = peak_lvl;
      holdNext  = hold_cnt;
      stateNext = state;
      capture   = (in_lvl >= peak_lvl) && (in_lvl != '0);
      if (capture) begin
         peakNext  = in_lvl;
         holdNext  = HOLD_LOAD;
         stateNext = HOLD;
      end else begin
         case (state)
            TRACK: begin
               peakNext = bar_lvl;
            end
            HOLD: begin
               if (hold_cnt == '0) begin
                  stateNext = FALL;
               end else begin
                  holdNext = hold_cnt - HW'(1);
               end
            end
            FALL: begin
               if (tick && (peak_lvl != '0)) begin
                  peakNext = peak_lvl - 4'd1;
               end
               if (peakNext <= barNext) begin
                  stateNext = TRACK;
               end
            end
            default: begin
               stateNext = TRACK;
            end
         endcase
      end
   end

   // The dot is a single LED at the peak level; peak_en only gates this
   // mask, so switching it never disturbs the ballistics state.
   always_comb begin
      dotMask = '0;
      if (peak_en && (peak_lvl != '0)) begin
         dotMask = level2dot(peak_lvl);
      end
   end

   // All pipeline registers: stage 1 decodes the input level, stage 2 holds
   // bar/peak state, stage 3 drives the LEDs. Reset clears everything at
   // once so the LEDs go dark without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_lvl   <= '0;
         bar_lvl  <= '0;
         peak_lvl <= '0;
         hold_cnt <= '0;
         state    <= TRACK;
         LED_out  <= '0;
      end else begin
         in_lvl   <= therm2level(LED_in);
         bar_lvl  <= barNext;
         peak_lvl <= peakNext;
         hold_cnt <= holdNext;
         state    <= stateNext;
         LED_out  <= level2therm(bar_lvl) | dotMask;
      end
   end

endmodule

// File: tb/tb_led_peak_hold.sv
// ---------------------------------------------------------------------------
// tb_led_peak_hold
// Directed bench for led_peak_hold with HOLD_CYCLES=8, DECAY_CYCLES=4.
// Each scenario starts from reset; reset is released on a falling clock
// edge, so the next rising edge is edge 1 and the decay tick lands on
// edges 4, 8, 12, ... Inputs change and outputs are sampled on falling
// edges; LED_out sampled after edge k reflects the bar/peak state after
// edge k-1.
// ---------------------------------------------------------------------------
module tb_led_peak_hold;
   import led_vu_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [7:0] LED_in;
   logic       peak_en;
   logic [7:0] LED_out;

   int totalCount;
   int badCount;
   int edgeNum;

   led_peak_hold #(
      .HOLD_CYCLES  (8),
      .DECAY_CYCLES (4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .LED_in  (LED_in),
      .peak_en (peak_en),
      .LED_out (LED_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison funnels through here so the counts stay honest.
   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      totalCount++;
      if (observed !== expected) begin
         badCount++;
         $display("[TB] FAIL %s: LED_out=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] inCode, input logic enable);
      LED_in  = inCode;
      peak_en = enable;
   endtask

   // Advance to the falling edge after rising edge number k.
   task automatic runTo(input int k);
      while (edgeNum < k) begin
         @(posedge clk);
         edgeNum++;
         @(negedge clk);
      end
   endtask

   task automatic checkAt(input int k, input string tag, input logic [7:0] expected);
      runTo(k);
      checkOutput(tag, LED_out, expected);
   endtask

   // Hold reset for two clocks with the given input already applied, check
   // the dark output, then release on a falling edge.
   task automatic resetWith(input logic [7:0] inCode, input logic enable);
      applyStimulus(inCode, enable);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("inReset", LED_out, 8'h00);
      rst_n   = 1'b1;
      edgeNum = 0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      totalCount = 0;
      badCount   = 0;
      edgeNum    = 0;
      rst_n      = 1'b0;
      LED_in     = 8'h00;
      peak_en    = 1'b1;
      @(negedge clk);

      // Scenario 1: full scale through reset, 3-clock attack latency.
      $display("[TB] scenario 1: reset and full-scale attack");
      resetWith(8'hFF, 1'b1);
      checkAt(2, "s1Edge2", 8'h00);
      checkAt(3, "s1Edge3", 8'hFF);

      // Scenario 2: one-cycle level-6 pulse with the peak dot shown.
      $display("[TB] scenario 2: pulse decay with peak dot");
      resetWith(8'h3F, 1'b1);
      runTo(1);
      applyStimulus(8'h00, 1'b1);
      checkAt(3,  "s2Edge3",  8'h3F);
      checkAt(5,  "s2Edge5",  8'h3F);
      checkAt(9,  "s2Edge9",  8'h2F);
      checkAt(12, "s2Edge12", 8'h2F);
      checkAt(13, "s2Edge13", 8'h17);
      checkAt(17, "s2Edge17", 8'h0B);
      checkAt(21, "s2Edge21", 8'h05);
      checkAt(25, "s2Edge25", 8'h02);
      checkAt(29, "s2Edge29", 8'h01);
      checkAt(33, "s2Edge33", 8'h00);

      // Scenario 3: same pulse, bar only.
      $display("[TB] scenario 3: pulse decay, bar only");
      resetWith(8'h3F, 1'b0);
      runTo(1);
      applyStimulus(8'h00, 1'b0);
      checkAt(3,  "s3Edge3",  8'h3F);
      checkAt(5,  "s3Edge5",  8'h1F);
      checkAt(9,  "s3Edge9",  8'h0F);
      checkAt(13, "s3Edge13", 8'h07);
      checkAt(17, "s3Edge17", 8'h03);
      checkAt(21, "s3Edge21", 8'h01);
      checkAt(25, "s3Edge25", 8'h00);

      // Scenario 4: steady level 4 with a single full-scale spike; the
      // peak falls back and merges with the bar. peak_en is dropped for
      // one sample to show it touches only the output.
      $display("[TB] scenario 4: spike over steady level");
      resetWith(8'h0F, 1'b1);
      runTo(5);
      applyStimulus(8'hFF, 1'b1);
      runTo(6);
      applyStimulus(8'h0F, 1'b1);
      checkAt(7,  "s4Edge7",  8'h0F);
      checkAt(8,  "s4Edge8",  8'hFF);
      checkAt(9,  "s4Edge9",  8'hFF);
      checkAt(13, "s4Edge13", 8'hBF);
      applyStimulus(8'h0F, 1'b0);
      checkAt(14, "s4PeakOff", 8'h3F);
      applyStimulus(8'h0F, 1'b1);
      checkAt(17, "s4Edge17", 8'h5F);
      checkAt(21, "s4Edge21", 8'h2F);
      checkAt(25, "s4Edge25", 8'h1F);
      checkAt(29, "s4Edge29", 8'h0F);
      checkAt(33, "s4Edge33", 8'h0F);

      // Scenario 5: a second equal-level hit restarts the hold.
      $display("[TB] scenario 5: re-capture restarts hold");
      resetWith(8'h1F, 1'b1);
      runTo(1);
      applyStimulus(8'h00, 1'b1);
      checkAt(3, "s5Edge3", 8'h1F);
      runTo(5);
      applyStimulus(8'h1F, 1'b1);
      runTo(6);
      applyStimulus(8'h00, 1'b1);
      checkAt(10, "s5Edge10", 8'h1F);
      checkAt(13, "s5Edge13", 8'h17);
      checkAt(16, "s5Edge16", 8'h17);
      checkAt(17, "s5Edge17", 8'h0B);

      // Scenario 6: malformed input, then reset in the middle of FALL.
      $display("[TB] scenario 6: malformed input and reset mid-fall");
      resetWith(8'h21, 1'b1);
      checkAt(3, "s6Malformed", 8'h3F);
      applyStimulus(8'h00, 1'b1);
      checkAt(20, "s6MidFall", 8'h17);
      rst_n = 1'b0;
      #1;
      checkOutput("s6AsyncClear", LED_out, 8'h00);
      @(negedge clk);
      rst_n   = 1'b1;
      edgeNum = 0;
      checkAt(3, "s6AfterRelease", 8'h00);
      checkAt(6, "s6Quiet", 8'h00);

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
